// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: FSM state encoding and add/subtract mode constants shared by serial_addsub
package serial_addsub_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/serial_addsub_adder.sv
// full_adder / ripple_adder: 1-bit full adder and DIGIT-bit ripple chain (s, cout, c_msb = carry into top bit)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);
  logic [DIGIT:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: DIGIT-bits-per-cycle add/sub; ports clk rst start sub a b cin -> busy done sum cout ovf
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d, nres;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [DIGIT-1:0] dsum;
  logic dco, dcm;
  ripple_adder #(.DIGIT(DIGIT)) u_add (
    .a(a_q[DIGIT-1:0]), .b(b_q[DIGIT-1:0]), .cin(c_q), .s(dsum), .cout(dco), .c_msb(dcm)
  );
  assign nres = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q != S_RUN && start) begin
      state_d = S_RUN;
      a_d     = a;
      b_d     = (sub == MODE_SUB) ? ~b : b;
      c_d     = cin ^ sub;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      a_d   = a_q >> DIGIT;
      b_d   = b_q >> DIGIT;
      c_d   = dco;
      cnt_d = cnt_q + 1'b1;
      res_d = nres;
      if (cnt_q == CW'(N - 1)) begin
        state_d = S_DONE;
        sum_d   = nres;
        cout_d  = dco;
        ovf_d   = dcm ^ dco;
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy = state_q == S_RUN;
  assign done = state_q == S_DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: table, hand-written and random checks of serial_addsub at DIGIT=1 and DIGIT=4
module tb_serial_addsub;
  logic clk = 0, rst = 1, start1 = 0, start4 = 0, sub = 0, cin = 0;
  logic [7:0] a = 0, b = 0, sum1, sum4;
  logic busy1, done1, cout1, ovf1, busy4, done4, cout4, ovf4;
  logic [9:0] prev1 = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  serial_addsub #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );
  typedef struct {logic [7:0] a, b; logic ci, s; logic [9:0] exp;} vec_t;
  vec_t tbl[9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic s);
    int r, sr;
    logic [31:0] rv;
    r  = s ? int'(x) - int'(y) - int'(ci) : int'(x) + int'(y) + int'(ci);
    sr = s ? int'($signed(x)) - int'($signed(y)) - int'(ci) : int'($signed(x)) + int'($signed(y)) + int'(ci);
    rv = r;
    return {(sr > 127 || sr < -128), (s ? (r >= 0) : (r > 255)), rv[7:0]};
  endfunction
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts,
                        input int poke, input logic [9:0] exp);
    bit g1 = 0, g4 = 0;
    a = ta; b = tb; cin = tc; sub = ts; start1 = 1; start4 = 1;
    @(negedge clk);
    start1 = 0; start4 = 0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    chk("busy_d1", busy1, 1);
    chk("busy_d4", busy4, 1);
    for (int e = 1; e <= 12 && !(g1 && g4); e++) begin
      @(negedge clk);
      start1 = (e == poke);
      if (e == poke) begin a = ~ta; b = ~tb; end
      if (done4 && !g4) begin
        g4 = 1;
        chk("lat_d4", e, 2);
        chk("res_d4", {ovf4, cout4, sum4}, exp);
      end
      if (done1 && !g1) begin
        g1 = 1;
        chk("lat_d1", e, 8);
        chk("res_d1", {ovf1, cout1, sum1}, exp);
      end else if (!g1) begin
        chk("hold_d1", {busy1, ovf1, cout1, sum1}, {1'b1, prev1});
      end
    end
    start1 = 0;
    if (!g1) chk("timeout_d1", 0, 1);
    if (!g4) chk("timeout_d4", 0, 1);
    prev1 = exp;
  endtask
  initial begin
    logic [7:0] ra, rb;
    logic rc, rs;
    int ndone, e1;
    tbl[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 10'h010};
    tbl[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 10'h101};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 10'h280};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 10'h300};
    tbl[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 10'h0FE};
    tbl[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 10'h37F};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 10'h100};
    tbl[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 10'h0FF};
    tbl[8] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 10'h1FF};
    start1 = 1; start4 = 1;
    repeat (2) @(negedge clk);
    start1 = 0; start4 = 0;
    chk("rst_d1", {busy1, done1, ovf1, cout1, sum1}, 0);
    chk("rst_d4", {busy4, done4, ovf4, cout4, sum4}, 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, -1, tbl[i].exp);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 3, 10'h046);
    a = 8'h30; b = 8'h50; cin = 0; sub = 0; start1 = 1; start4 = 0;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1; sub = 1;
    ndone = 0; e1 = 0;
    for (int e = 1; e <= 25 && ndone < 2; e++) begin
      @(negedge clk);
      if (done1) begin
        ndone++;
        if (ndone == 1) begin
          e1 = e;
          chk("b2b_lat1", e, 8);
          chk("b2b_res1", {ovf1, cout1, sum1}, model(8'h30, 8'h50, 1'b0, 1'b0));
        end else begin
          chk("b2b_gap", e - e1, 9);
          chk("b2b_res2", {ovf1, cout1, sum1}, model(8'h10, 8'h20, 1'b1, 1'b1));
          start1 = 0;
        end
      end
    end
    start1 = 0;
    if (ndone < 2) chk("b2b_timeout", ndone, 2);
    prev1 = model(8'h10, 8'h20, 1'b1, 1'b1);
    @(negedge clk);
    a = 8'h44; b = 8'h22; cin = 0; sub = 0; start1 = 1; start4 = 1;
    @(negedge clk);
    start1 = 0; start4 = 0;
    repeat (3) @(negedge clk);
    rst = 1; start1 = 1; start4 = 1;
    repeat (2) @(negedge clk);
    chk("midrst_d1", {busy1, done1, ovf1, cout1, sum1}, 0);
    chk("midrst_d4", {busy4, done4, ovf4, cout4, sum4}, 0);
    rst = 0; start1 = 0; start4 = 0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      ndone += int'(done1 | busy1);
    end
    chk("midrst_idle", ndone, 0);
    prev1 = 0;
    run_op(8'h44, 8'h22, 1'b0, 1'b0, -1, 10'h066);
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      run_op(ra, rb, rc, rs, (i % 5 == 0) ? 1 + int'($urandom_range(0, 6)) : -1, model(ra, rb, rc, rs));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor, the sequential successor to the lab's 1-bit full adder.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, using a registered carry.
- Uses a start/busy/done handshake.
- Reports sum, carry-out and signed overflow.
- Used by later labs as a shared arithmetic unit behind a simple controller FSM.

Parameters:
- WIDTH, 8: operand and result width in bits; must be at least 2.
- DIGIT, 1: bits processed per cycle; must divide WIDTH. N = WIDTH/DIGIT is the number of cycles per operation.

Ports:
- clk  in  1  : system clock, rising edge.
- rst  in  1  : synchronous, active-high reset.
- start  in  1  : request a new operation; sampled only when not busy.
- sub  in  1  : 0 = add (a+b+cin); 1 = subtract (a-b-cin).
- a  in  WIDTH  : operand A, sampled with start.
- b  in  WIDTH  : operand B, sampled with start.
- cin  in  1  : carry-in when adding; borrow-in when subtracting.
- busy  out  1  : high while digits are being processed.
- done  out  1  : one-cycle pulse; result valid from this cycle on.
- sum  out  WIDTH  : result.
- cout  out  1  : final carry. In subtract mode 1 = no borrow, 0 = borrow.
- ovf  out  1  : two's-complement overflow.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk/rst.
- Reset drives state to IDLE, and busy, done, sum, cout and ovf to 0. The internal operand shift registers and carry are also cleared.
- States:
  - IDLE: on start=1, go to RUN.
  - RUN: stays N cycles (digit counter 0..N-1), then goes to DONE.
  - DONE: lasts exactly one cycle. Goes to RUN if start=1, else IDLE.
- Capture at the accepting edge:
  - A register <= a.
  - B register <= sub ? ~b : b.
  - carry <= cin ^ sub.
  - digit counter <= 0.
  - The sub flag is held internally, so changes to sub, a, b or cin during RUN have no effect.
- Each RUN cycle:
  - Add the low DIGIT bits of A and B plus carry (DIGIT-bit ripple).
  - Shift the result digit into the top of an internal result register.
  - Shift A and B right by DIGIT.
  - carry <= digit carry-out.
- The final digit cycle also registers carry-into-MSB for the overflow calculation.
- At the edge leaving RUN:
  - sum <= full result.
  - cout <= final carry.
  - ovf <= carry-into-MSB ^ final carry.
  - done=1 for the DONE cycle.
- Latency: with start sampled at edge 0, done and the new sum/cout/ovf are visible after edge N and held until the next completion or reset. busy=1 after edges 0..N-1.
- Outputs sum/cout/ovf change only at completion edges, never mid-operation.
- start while busy=1 is ignored; the request is not queued.
- start in the DONE cycle is accepted, giving back-to-back operations with one DONE cycle between them.
- rst during RUN aborts the operation: next state IDLE, all outputs 0, partial result discarded.
- Carry-out wraps silently: sum is mod 2^WIDTH.
- DIGIT=WIDTH gives a 1-cycle RUN.

Decomposition:
- Shared package/include holds:
  - state encoding constants: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - the ADD/SUB mode constants.
- One combinational sub-module, ripple_adder #(DIGIT), built from full_adder instances. It has outputs s[DIGIT-1:0], cout, and c_msb (carry into its top bit).
- Counter width is clog2(N), minimum 1.

Test Plan:
- Reset: assert rst for 2 cycles mid-random stimulus -> busy=0, done=0, sum=0, cout=0, ovf=0; start is ignored while rst=1.
- Add (WIDTH=8, DIGIT=1): a=8'h0F, b=8'h01, cin=0, sub=0 -> busy for 8 cycles, done pulse after edge 8, sum=8'h10, cout=0, ovf=0; a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0.
- Overflow: a=8'h7F, b=8'h01, add -> sum=8'h80, cout=0, ovf=1; with DIGIT=4, a=8'h80, b=8'h80 -> done after 2 cycles, sum=8'h00, cout=1, ovf=1.
- Subtract: a=8'h05, b=8'h07, cin=0, sub=1 -> sum=8'hFE, cout=0 (borrow), ovf=0; a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Handshake: start pulsed at cycle 3 of RUN with different operands -> ignored, result matches the first operands. start held during DONE -> new operation begins immediately, done pulses spaced N+1 cycles apart.
- Reset mid-op: rst at RUN cycle 3 -> IDLE next cycle, no done pulse, outputs 0. A fresh start afterwards completes correctly.
